// File: rtl/systolic_pkg.sv
// Shared types for the systolic feed path: MAC operand word, lane row, scheduler states.
// Types only, so there is no latency and no backpressure.
package systolic_pkg;

    localparam int MAC_W_C         = 16;
    localparam int LANES_DEFAULT_C = 4;

    typedef logic [MAC_W_C-1:0] t_mac_data;
    typedef t_mac_data [LANES_DEFAULT_C-1:0] t_lane_row;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT,
        DONE
    } t_sched_state;

endpackage

// File: rtl/systolic_feed_scheduler_skew.sv
// Per-lane skew stage: delays one operand word and its valid by delay_c cycles, combinational when delay_c=0.
// Fixed latency delay_c; no backpressure, because the array consumes one word per cycle unconditionally.
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int delay_c = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  t_mac_data src_dat,
    input  logic      src_vld,
    output t_mac_data dly_dat,
    output logic      dly_vld
);

    generate
        if (delay_c == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dly_dat        = src_dat;
            assign dly_vld        = src_vld;
        end else begin : g_pipe
            t_mac_data          dat_q [delay_c];
            logic [delay_c-1:0] vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < delay_c; j++) begin
                        dat_q[j] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    dat_q[0] <= src_dat;
                    vld_q[0] <= src_vld;
                    for (int j = 1; j < delay_c; j++) begin
                        dat_q[j] <= dat_q[j-1];
                        vld_q[j] <= vld_q[j-1];
                    end
                end
            end

            assign dly_dat = dat_q[delay_c-1];
            assign dly_vld = vld_q[delay_c-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Streams k operand rows into the systolic array edge with a diagonal skew, then drains and signals done.
// Latency start->done is k+2*array_dim_c+2 cycles; start is ignored while busy, and nothing downstream can stall the feed.
module systolic_feed_scheduler
    import systolic_pkg::*;
#(
    parameter int array_dim_c = 4,
    parameter int depth_max_c = 16
) (
    input  logic                               clock_i,
    input  logic                               resetn_i,
    input  logic                               start_i,
    input  logic [$clog2(depth_max_c+1)-1:0]   k_len_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               acc_clear_o,
    output logic                               rd_en_o,
    output logic [$clog2(depth_max_c)-1:0]     rd_addr_o,
    input  t_mac_data [array_dim_c-1:0]        rd_data_i,
    output t_mac_data [array_dim_c-1:0]        lane_data_o,
    output logic [array_dim_c-1:0]             lane_valid_o,
    output logic                               drain_o
);

    localparam int KW = $clog2(depth_max_c + 1);
    localparam int AW = $clog2(depth_max_c);
    localparam int WW = $clog2(2 * array_dim_c + 2);

    t_sched_state  state;
    logic [AW-1:0] row_cnt;
    logic [WW-1:0] wait_cnt;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] k_sat;

    assign k_sat     = (k_len_i > KW'(depth_max_c)) ? KW'(depth_max_c) : k_len_i;
    assign rd_addr_o = row_cnt;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state       <= IDLE;
            row_cnt     <= '0;
            wait_cnt    <= '0;
            k_reg       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            acc_clear_o <= 1'b0;
            rd_en_o     <= 1'b0;
            drain_o     <= 1'b0;
        end else begin
            acc_clear_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (k_sat == '0) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            k_reg       <= k_sat;
                            row_cnt     <= '0;
                            acc_clear_o <= 1'b1;
                            rd_en_o     <= 1'b1;
                            state       <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (KW'(row_cnt) == k_reg - KW'(1)) begin
                        rd_en_o  <= 1'b0;
                        row_cnt  <= '0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        row_cnt <= row_cnt + AW'(1);
                    end
                end
                WAIT: begin
                    // Drain covers the last array_dim_c of the 2*array_dim_c+1 wait cycles.
                    if (wait_cnt == WW'(2 * array_dim_c)) begin
                        drain_o <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                        drain_o  <= (wait_cnt >= WW'(array_dim_c));
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic                         rd_vld_q;
    logic                         stage_vld;
    t_mac_data [array_dim_c-1:0]  stage_dat;
    t_mac_data [array_dim_c-1:0]  skew_dat;
    logic [array_dim_c-1:0]       skew_vld;

    // Buffer returns data one cycle after the read; capture it into the output register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_vld_q  <= 1'b0;
            stage_vld <= 1'b0;
            stage_dat <= '0;
        end else begin
            rd_vld_q  <= rd_en_o;
            stage_vld <= rd_vld_q;
            stage_dat <= rd_vld_q ? rd_data_i : '0;
        end
    end

    for (genvar i = 0; i < array_dim_c; i++) begin : g_lane
        skew_delay_line #(
            .delay_c (i)
        ) u_skew (
            .clk     (clock_i),
            .rst_n   (resetn_i),
            .src_dat (stage_dat[i]),
            .src_vld (stage_vld),
            .dly_dat (skew_dat[i]),
            .dly_vld (skew_vld[i])
        );
    end

    assign lane_valid_o = skew_vld;

    always_comb begin
        lane_data_o = '0;
        for (int i = 0; i < array_dim_c; i++) begin
            lane_data_o[i] = skew_vld[i] ? skew_dat[i] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Directed bench for systolic_feed_scheduler: a 4-lane and a 1-lane instance with hand-derived cycle profiles.
module tb_systolic_feed_scheduler;
    import systolic_pkg::*;

    logic clk;
    logic resetn;

    logic       start4, busy4, done4, clr4, rd_en4, drain4;
    logic [4:0] k_len4;
    logic [3:0] rd_addr4;
    logic [3:0] lane_vld4;
    t_lane_row  rd_data4, lane_data4;

    logic             start1, busy1, done1, clr1, rd_en1, drain1;
    logic [4:0]       k_len1;
    logic [3:0]       rd_addr1;
    logic [0:0]       lane_vld1;
    t_mac_data [0:0]  rd_data1, lane_data1;

    t_lane_row mem4 [16];
    t_mac_data mem1 [16];

    int vectors;
    int miscompares;

    systolic_feed_scheduler #(.array_dim_c(4), .depth_max_c(16)) dut4 (
        .clock_i(clk), .resetn_i(resetn), .start_i(start4), .k_len_i(k_len4),
        .busy_o(busy4), .done_o(done4), .acc_clear_o(clr4), .rd_en_o(rd_en4),
        .rd_addr_o(rd_addr4), .rd_data_i(rd_data4), .lane_data_o(lane_data4),
        .lane_valid_o(lane_vld4), .drain_o(drain4)
    );

    systolic_feed_scheduler #(.array_dim_c(1), .depth_max_c(16)) dut1 (
        .clock_i(clk), .resetn_i(resetn), .start_i(start1), .k_len_i(k_len1),
        .busy_o(busy1), .done_o(done1), .acc_clear_o(clr1), .rd_en_o(rd_en1),
        .rd_addr_o(rd_addr1), .rd_data_i(rd_data1), .lane_data_o(lane_data1),
        .lane_valid_o(lane_vld1), .drain_o(drain1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffers with one cycle of read latency.
    always @(posedge clk) if (rd_en4) rd_data4 <= mem4[rd_addr4];
    always @(posedge clk) if (rd_en1) rd_data1[0] <= mem1[rd_addr1];

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #2;
        vectors++;
        if ({busy4, done4, clr4, rd_en4, rd_addr4, lane_vld4, lane_data4, drain4} !== '0) begin
            miscompares++;
            $display("FAIL reset4 outputs got %h want 0",
                     {busy4, done4, clr4, rd_en4, rd_addr4, lane_vld4, lane_data4, drain4});
        end
        vectors++;
        if ({busy1, done1, clr1, rd_en1, rd_addr1, lane_vld1, lane_data1, drain1} !== '0) begin
            miscompares++;
            $display("FAIL reset1 outputs got %h want 0",
                     {busy1, done1, clr1, rd_en1, rd_addr1, lane_vld1, lane_data1, drain1});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Full cycle profile of one tile on the 4-lane instance; k_eff is the saturated length.
    task automatic test_tile(input string name, input int k_in, input int k_eff);
        t_lane_row  exp_dat;
        logic [3:0] exp_vld;
        @(negedge clk);
        start4 = 1'b1;
        k_len4 = 5'(k_in);
        @(posedge clk);
        for (int c = 1; c <= k_eff + 11; c++) begin
            @(negedge clk);
            if (c == 1) start4 = 1'b0;
            exp_vld = '0;
            exp_dat = '0;
            for (int i = 0; i < 4; i++) begin
                if (c >= 3 + i && c <= k_eff + 2 + i) begin
                    exp_vld[i] = 1'b1;
                    exp_dat[i] = mem4[c-3-i][i];
                end
            end
            vectors++;
            if (rd_en4 !== 1'(c <= k_eff)) begin
                miscompares++;
                $display("FAIL %s cyc %0d rd_en got %b want %b", name, c, rd_en4, c <= k_eff);
            end
            if (c <= k_eff) begin
                vectors++;
                if (rd_addr4 !== 4'(c - 1)) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d rd_addr got %0d want %0d", name, c, rd_addr4, c - 1);
                end
            end
            vectors++;
            if (clr4 !== 1'(c == 1)) begin
                miscompares++;
                $display("FAIL %s cyc %0d acc_clear got %b want %b", name, c, clr4, c == 1);
            end
            vectors++;
            if (lane_vld4 !== exp_vld) begin
                miscompares++;
                $display("FAIL %s cyc %0d lane_valid got %b want %b", name, c, lane_vld4, exp_vld);
            end
            vectors++;
            if (lane_data4 !== exp_dat) begin
                miscompares++;
                $display("FAIL %s cyc %0d lane_data got %h want %h", name, c, lane_data4, exp_dat);
            end
            vectors++;
            if (drain4 !== 1'(c >= k_eff + 6 && c <= k_eff + 9)) begin
                miscompares++;
                $display("FAIL %s cyc %0d drain got %b want %b", name, c, drain4,
                         c >= k_eff + 6 && c <= k_eff + 9);
            end
            vectors++;
            if (done4 !== 1'(c == k_eff + 10)) begin
                miscompares++;
                $display("FAIL %s cyc %0d done got %b want %b", name, c, done4, c == k_eff + 10);
            end
            vectors++;
            if (busy4 !== 1'(c <= k_eff + 10)) begin
                miscompares++;
                $display("FAIL %s cyc %0d busy got %b want %b", name, c, busy4, c <= k_eff + 10);
            end
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start4 = 1'b1;
        k_len4 = 5'd0;
        @(posedge clk);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            vectors++;
            if ({busy4, done4} !== {1'(c == 1), 1'(c == 1)}) begin
                miscompares++;
                $display("FAIL zero_len cyc %0d busy,done got %b%b want %b%b", c, busy4, done4, c == 1, c == 1);
            end
            vectors++;
            if ({rd_en4, clr4, lane_vld4} !== '0) begin
                miscompares++;
                $display("FAIL zero_len cyc %0d rd_en,clr,lane_valid got %b want 0", c, {rd_en4, clr4, lane_vld4});
            end
        end
    endtask

    task automatic test_start_held();
        @(negedge clk);
        start4 = 1'b1;
        k_len4 = 5'd2;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            vectors++;
            if (clr4 !== 1'(c == 1 || c == 14)) begin
                miscompares++;
                $display("FAIL held cyc %0d acc_clear got %b want %b", c, clr4, c == 1 || c == 14);
            end
            vectors++;
            if (done4 !== 1'(c == 12 || c == 25)) begin
                miscompares++;
                $display("FAIL held cyc %0d done got %b want %b", c, done4, c == 12 || c == 25);
            end
            vectors++;
            if (busy4 !== 1'(!(c == 13 || c == 26))) begin
                miscompares++;
                $display("FAIL held cyc %0d busy got %b want %b", c, busy4, !(c == 13 || c == 26));
            end
            if (c == 14) start4 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_feed();
        @(negedge clk);
        start4 = 1'b1;
        k_len4 = 5'd8;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        #2;
        vectors++;
        if ({busy4, rd_en4, rd_addr4} !== {1'b1, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL abort pre-reset busy,rd_en,addr got %b want %b", {busy4, rd_en4, rd_addr4}, 6'b110001);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({busy4, done4, clr4, rd_en4, rd_addr4, lane_vld4, lane_data4, drain4} !== '0) begin
            miscompares++;
            $display("FAIL abort async outputs got %h want 0",
                     {busy4, done4, clr4, rd_en4, rd_addr4, lane_vld4, lane_data4, drain4});
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({done4, busy4, lane_vld4} !== '0) begin
                miscompares++;
                $display("FAIL abort quiet cyc %0d done,busy,lane_valid got %b want 0", c, {done4, busy4, lane_vld4});
            end
        end
        test_tile("after_abort", 1, 1);
    endtask

    task automatic test_dim1();
        t_mac_data exp_d;
        @(negedge clk);
        start1 = 1'b1;
        k_len1 = 5'd2;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            exp_d = '0;
            if (c >= 3 && c <= 4) exp_d = mem1[c-3];
            vectors++;
            if ({rd_en1, clr1} !== {1'(c <= 2), 1'(c == 1)}) begin
                miscompares++;
                $display("FAIL dim1 cyc %0d rd_en,clr got %b%b want %b%b", c, rd_en1, clr1, c <= 2, c == 1);
            end
            vectors++;
            if (lane_vld1[0] !== 1'(c >= 3 && c <= 4) || lane_data1[0] !== exp_d) begin
                miscompares++;
                $display("FAIL dim1 cyc %0d lane got v=%b d=%0d want v=%b d=%0d", c, lane_vld1[0], lane_data1[0],
                         c >= 3 && c <= 4, exp_d);
            end
            vectors++;
            if ({drain1, done1, busy1} !== {1'(c == 5), 1'(c == 6), 1'(c <= 6)}) begin
                miscompares++;
                $display("FAIL dim1 cyc %0d drain,done,busy got %b%b%b want %b%b%b", c, drain1, done1, busy1,
                         c == 5, c == 6, c <= 6);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        start4      = 1'b0;
        start1      = 1'b0;
        k_len4      = '0;
        k_len1      = '0;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 4; i++) mem4[r][i] = t_mac_data'(4 * r + i + 1);
            mem1[r] = t_mac_data'(3 * r + 7);
        end

        test_reset();
        test_tile("basic_k3", 3, 3);
        test_zero_len();
        test_start_held();
        test_reset_mid_feed();
        test_tile("k16", 16, 16);
        test_tile("k20_sat", 20, 16);
        test_dim1();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feed_scheduler.md
# systolic_feed_scheduler

Sequences one operand tile into the systolic MAC array. On a start command it reads `k_len` operand rows from the operand buffer, one row per cycle. It feeds the row elements into the array's edge lanes with the diagonal skew a systolic array needs: lane i is delayed i cycles. It then signals a drain window and reports completion. It sits between the tile command path and the array's west/north input edge, and owns the array's accumulator-clear and drain controls.

## Interface
- `array_dim_c`, default 4: number of edge lanes (array side length); at least 1.
- `depth_max_c`, default 16: maximum rows per tile (k dimension).
- `clock_i` in, 1: the single system clock.
- `resetn_i` in, 1: reset, asynchronous and active-low.
- `start_i` in, 1: tile start request, sampled in IDLE only.
- `k_len_i` in, $clog2(depth_max_c+1): rows in the tile, 0..depth_max_c; sampled with `start_i`.
- `busy_o` out, 1: high in every state except IDLE.
- `done_o` out, 1: one-cycle completion pulse.
- `acc_clear_o` out, 1: one-cycle pulse that clears the array accumulators.
- `rd_en_o` out, 1: operand buffer read enable.
- `rd_addr_o` out, $clog2(depth_max_c): operand row address.
- `rd_data_i` in, array_dim_c × t_mac_data: operand row, valid 1 cycle after `rd_en_o`.
- `lane_data_o` out, array_dim_c × t_mac_data: skewed lane data into the array.
- `lane_valid_o` out, array_dim_c: per-lane valid.
- `drain_o` out, 1: high while the array flushes partial results.

## Operation
- States: IDLE, FEED, WAIT, DONE.
- IDLE:
  - `start_i`=1 with `k_len_i`>0: latch k, pulse `acc_clear_o`, go to FEED.
  - `start_i`=1 with `k_len_i`=0: go to DONE directly; no reads, no valids, no `acc_clear_o`.
- FEED, k cycles:
  - `rd_en_o`=1; `rd_addr_o` counts 0..k-1.
  - Go to WAIT after the address k-1 cycle.
- WAIT, 2·array_dim_c+1 cycles:
  - Covers read latency, output register, skew, then drain.
  - `drain_o`=1 for the last array_dim_c cycles of WAIT.
- DONE: `done_o`=1 for one cycle, then IDLE.
- Skew path:
  - The data captured from `rd_data_i[i]` is registered, then delayed i further cycles.
  - It appears on `lane_data_o[i]` with `lane_valid_o[i]`=1.
  - When a lane is not valid, its `lane_data_o` is forced to 0.
- `start_i` outside IDLE is ignored and never queued.
- `k_len_i` > depth_max_c is saturated to depth_max_c.
- Async reset, including mid-tile:
  - All outputs go to 0 immediately and the state returns to IDLE.
  - Skew line contents are cleared.
  - No `done_o` is produced for the aborted tile.
- Reset value of every output is 0.

## Timing
- Reference timing, with start accepted on edge 0:
  - Cycle 1: `acc_clear_o`=1.
  - Cycles 1..k: `rd_en_o`=1.
  - Cycles 2..k+1: `rd_data_i` valid.
  - Cycles 3+i..k+2+i: `lane_valid_o[i]`=1.
  - Last lane goes idle after cycle k+array_dim_c+1.
  - Cycles k+array_dim_c+2..k+2·array_dim_c+1: `drain_o`=1.
  - Cycle k+2·array_dim_c+2: `done_o`=1.
  - Cycle k+2·array_dim_c+3: IDLE, `busy_o`=0, a new start can be accepted.
- Zero-length tile: `busy_o`=1 and `done_o`=1 in cycle 1; IDLE in cycle 2.
- Back-to-back tiles: minimum spacing is k+2·array_dim_c+3 cycles between accepted starts; tiles never overlap.

## Structure
- `systolic_pkg` (shared): `t_mac_data`, `t_sched_state` enum (IDLE/FEED/WAIT/DONE), and the lane-array typedef.
- Sub-module `skew_delay_line`:
  - Parameter: `delay_c`.
  - Delays data and valid together; reset clears both.
  - `delay_c`=0 passes through combinationally.
  - Instantiated once per lane with `delay_c`=i.
- Counters:
  - Row counter, $clog2(depth_max_c) bits.
  - Wait counter, $clog2(2·array_dim_c+2) bits.

## Test plan
1. array_dim_c=4; start with k=3, rows {1,2,3,4},{5,6,7,8},{9,10,11,12} → `rd_addr_o` 0,1,2 on cycles 1–3. Lane 0 shows 1,5,9 on cycles 3–5; lane 3 shows 4,8,12 on cycles 6–8. `drain_o` on cycles 9–12; `done_o` on cycle 13.
2. k=0 → no `rd_en_o`, no `acc_clear_o`, `done_o` on cycle 1, `busy_o` low by cycle 2.
3. `start_i` held high through a k=2 tile → exactly one tile runs. Second start is accepted on the first IDLE cycle (cycle 13 when array_dim_c=4).
4. `resetn_i` low during FEED (cycle 2 of k=8) → all outputs 0 asynchronously, no `done_o`. A new k=1 tile afterwards produces clean lane output with no stale data.
5. k=depth_max_c=16, then `k_len_i`=20 → both run 16 reads at addresses 0..15, and `done_o` on cycle 26.
6. array_dim_c=1, k=2 → lane 0 valid on cycles 3–4, `drain_o` on cycle 5, `done_o` on cycle 6.
